// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with majority-vote sampling, glitch-rejecting
// start detection and a show-ahead FIFO holding each word with its error flags.

module fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   data_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    // full is judged before any same-cycle read, so a write while full drops
    assign w_wr = wr_en && !full;
    assign w_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout       = r_mem[r_rptr];
    assign empty      = (r_count == '0);
    assign full       = (r_count == L_FULL);
    assign data_count = r_count;

endmodule

module uart_rx_fifo #(
    parameter int CLK_IN    = 100000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 512
) (
    input  logic                     clk,
    input  logic                     srst_n,
    input  logic                     rx,
    input  logic                     rd_en,
    output logic [DATA_BITS-1:0]     dout,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   data_count,
    output logic                     overrun,
    input  logic                     clr_overrun,
    output logic                     busy
);

    localparam int N  = CLK_IN / BAUD;
    localparam int FW = DATA_BITS + 2;

    localparam logic [15:0] L_WEND  = 16'(N - 1);
    localparam logic [15:0] L_HALF  = 16'(N / 2);
    localparam logic [3:0]  L_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  L_SLAST = 4'(STOP_BITS - 1);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    state_t               r_state;
    logic                 r_meta;
    logic                 r_rxs;
    logic [15:0]          r_cnt;
    logic [15:0]          r_ones;
    logic [3:0]           r_bitn;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_brk;
    logic                 r_wr_en;
    logic [FW-1:0]        r_wdata;
    logic                 r_overrun;

    logic [15:0]          w_ones_nx;
    logic                 w_wend;
    logic                 w_bit;
    logic                 w_fifo_srst;
    logic                 w_full;
    logic [FW-1:0]        w_fdout;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_meta <= 1'b1;
            r_rxs  <= 1'b1;
        end else begin
            r_meta <= rx;
            r_rxs  <= r_meta;
        end
    end

    assign w_ones_nx = r_ones + {15'd0, r_rxs};
    assign w_wend    = (r_cnt == L_WEND);
    assign w_bit     = (w_ones_nx > L_HALF);

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ones  <= '0;
            r_bitn  <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_brk   <= 1'b0;
            r_wr_en <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_state != S_IDLE && !r_brk) begin
                if (w_wend) begin
                    r_cnt  <= '0;
                    r_ones <= '0;
                end else begin
                    r_cnt  <= r_cnt + 16'd1;
                    r_ones <= w_ones_nx;
                end
            end
            case (r_state)
                S_IDLE: begin
                    // the detecting cycle is the first sample of the start window
                    if (!r_rxs) begin
                        r_cnt   <= 16'd1;
                        r_ones  <= '0;
                        r_bitn  <= '0;
                        r_par   <= 1'b0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                        r_brk   <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_wend) begin
                        r_state <= w_bit ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_wend) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_bit;
                        r_bitn  <= r_bitn + 4'd1;
                        if (r_bitn == L_DLAST) begin
                            r_bitn  <= '0;
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_wend) begin
                        r_perr  <= (PARITY == 1) ? !(r_par ^ w_bit)
                                                 : (r_par ^ w_bit);
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // a line still low after the frame must rise before re-arming
                    if (r_brk) begin
                        if (r_rxs) begin
                            r_brk   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_wend) begin
                        r_bitn <= r_bitn + 4'd1;
                        if (!w_bit) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_bitn == L_SLAST) begin
                            r_bitn  <= '0;
                            r_wr_en <= 1'b1;
                            r_wdata <= {r_ferr | !w_bit, r_perr, r_shift};
                            if (r_rxs) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_brk <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_overrun <= 1'b0;
        end else if (r_wr_en && w_full) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign w_fifo_srst = !srst_n;

    fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .srst       (w_fifo_srst),
        .wr_en      (r_wr_en),
        .din        (r_wdata),
        .rd_en      (rd_en),
        .dout       (w_fdout),
        .empty      (empty),
        .full       (w_full),
        .data_count (data_count)
    );

    assign full       = w_full;
    assign dout       = w_fdout[DATA_BITS-1:0];
    assign parity_err = w_fdout[DATA_BITS];
    assign frame_err  = w_fdout[DATA_BITS+1];
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: 8E2, N=16, DEPTH=4; frames are built
// from intended bit values and the expected FIFO words queued at send time.

module tb_uart_rx_fifo;

    localparam int N     = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          srst_n = 1'b0;
    logic          rx = 1'b1;
    logic          rd_en = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [DB-1:0] dout;
    logic          parity_err;
    logic          frame_err;
    logic          empty;
    logic          full;
    logic [2:0]    data_count;
    logic          overrun;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_IN    (16),
        .BAUD      (1),
        .DATA_BITS (DB),
        .PARITY    (2),
        .STOP_BITS (2),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .srst_n      (srst_n),
        .rx          (rx),
        .rd_en       (rd_en),
        .dout        (dout),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .empty       (empty),
        .full        (full),
        .data_count  (data_count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .busy        (busy)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [9:0] exp_q[$];
    bit         rd_enable = 1'b0;
    bit         exp_ovr = 1'b0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // monitor: pop and compare whenever the FIFO shows an entry
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (rd_enable && srst_n && !empty) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got %0h/%0b/%0b, expected none",
                             dout, parity_err, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_data", 32'(dout), 32'(e[7:0]));
                    chk("head_perr", 32'(parity_err), 32'(e[8]));
                    chk("head_ferr", 32'(frame_err), 32'(e[9]));
                end
                rd_en = 1'b1;
            end
        end
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            rx = v;
        end
    endtask

    task automatic drive_bit(input logic v, input bit noisy);
        int off;
        off = $urandom_range(0, N - 5);
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            rx = (noisy && c >= off && c < off + 5) ? ~v : v;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit pbad,
                        input logic s1, input logic s2, input bit noisy);
        logic p;
        p = (^d) ^ pbad;
        drive(1'b0, N);
        for (int i = 0; i < DB; i++) begin
            drive_bit(d[i], noisy);
        end
        drive(p, N);
        drive(s1, N);
        drive(s2, N);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back({~(s1 & s2), pbad, d});
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        rd_enable = 1'b1;
        while ((exp_q.size() != 0 || !empty) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL drain: %0d entries still expected, empty=%0b after %0d cycles",
                     exp_q.size(), empty, t);
        end
        @(negedge clk);
        rd_enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(data_count), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);

        send(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        settle(6);
        chk("count_1", 32'(data_count), 1);
        send(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        settle(6);
        chk("count_2", 32'(data_count), 2);
        drain();

        drive(1'b0, 4);
        drive(1'b1, 4);
        chk("glitch_busy", 32'(busy), 1);
        t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("glitch_busy_len", 32'(t >= 8 && t <= 16), 1);
        chk("glitch_no_write", 32'(empty), 1);

        rd_enable = 1'b1;
        send(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        settle(6);
        send(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
        settle(6);
        drain();

        send(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 40);
        chk("break_busy", 32'(busy), 1);
        chk("break_count", 32'(data_count), 1);
        settle(10);
        chk("break_idle", 32'(busy), 0);
        chk("break_norepeat", 32'(data_count), 1);
        drain();

        for (int k = 0; k < 5; k++) begin
            send(8'($urandom), 1'($urandom % 2), 1'b1, 1'b1, 1'b0);
            settle(6);
            if (k == 3) begin
                chk("ovr_full", 32'(full), 1);
                chk("ovr_count4", 32'(data_count), 4);
                chk("ovr_not_yet", 32'(overrun), 0);
            end
        end
        chk("ovr_set", 32'(overrun), 32'(exp_ovr));
        chk("ovr_count_hold", 32'(data_count), 4);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        @(negedge clk);
        exp_ovr = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'(exp_ovr));
        drain();

        rd_enable = 1'b1;
        send(8'h96, 1'b0, 1'b1, 1'b1, 1'b1);
        settle(6);
        drain();

        drive(1'b0, N);
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'($urandom), 1'b0);
        end
        srst_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_count", 32'(data_count), 0);
        rd_enable = 1'b1;
        send(8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
        settle(6);
        drain();

        rd_enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send(8'($urandom), 1'($urandom % 4 == 0),
                 1'($urandom % 5 != 0), 1'($urandom % 5 != 0),
                 1'($urandom % 2));
            settle($urandom_range(6, 9));
        end
        drain();
        chk("final_overrun", 32'(overrun), 0);
        chk("final_queue", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 serial receiver.
- Configurable data width, parity and stop-bit count; start-bit glitch rejection; per-bit majority sampling.
- Reports framing, parity and overrun errors; buffers received words with their error flags in the team's `fifo`.
- Sits between an off-chip RX pin and any host logic that pops bytes via `rd_en`.

Parameters:
- CLK_IN, 100000000: input clock frequency in Hz.
- BAUD, 115200: line rate in bits/s. Bit period is N = CLK_IN/BAUD, integer-truncated. Requires N >= 4 and N < 2^16.
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- DEPTH, 512: FIFO depth in entries; must be a power of 2.

Ports:
- clk, in, 1: single clock for the whole block.
- srst_n, in, 1: synchronous, active-low reset.
- rx, in, 1: asynchronous serial line; idles high.
- rd_en, in, 1: pop one FIFO entry. Ignored when empty.
- dout, out, DATA_BITS: data field of the FIFO head.
- parity_err, out, 1: parity-error flag of the FIFO head.
- frame_err, out, 1: framing-error flag of the FIFO head.
- empty, out, 1: FIFO empty.
- full, out, 1: FIFO full.
- data_count, out, $clog2(DEPTH)+1: FIFO occupancy.
- overrun, out, 1: sticky flag; a completed frame was dropped because the FIFO was full.
- clr_overrun, in, 1: clears `overrun`.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset
  - `srst_n == 0` at a clk edge puts the block in IDLE and clears all counters, `overrun`, `busy` and the FIFO (the FIFO's active-high `srst` is driven with `!srst_n`).
  - After reset: `empty = 1`, `full = 0`, `data_count = 0`, `overrun = 0`, `busy = 0`.
  - Reset mid-frame abandons the frame; nothing is written.
- Input synchronisation
  - `rx` passes through a 2-flop synchroniser (reset value 1); the FSM uses only the synchronised value `rxs`.
  - Adds 2 cycles of latency.
- Sampling
  - Every bit window lasts exactly N cycles.
  - A 16-bit ones-counter accumulates `rxs` over the window.
  - The bit value is 1 iff ones > N/2 (integer), i.e. majority vote.
- State machine (one-hot): IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `rxs == 0`, start the bit counter at 1 and the ones-counter at 0, then go to START.
  - START: at window end, if the sampled bit is 0 go to DATA; otherwise it is a glitch: return to IDLE with no write.
  - DATA: shift the sampled bits into the LSB-first shift register. After DATA_BITS windows go to PARITY if PARITY != 0, else to STOP.
  - PARITY:
    - Odd parity error when the XOR of data and the parity bit is 0.
    - Even parity error when that XOR is 1.
  - STOP: sample STOP_BITS windows. `frame_err` is set if any stop bit samples as 0.
- Frame completion (end of the last stop window)
  - Write {frame_err, parity_err, data} to the FIFO with a single-cycle `wr_en`.
  - If the FIFO is full that cycle, do not write and set `overrun`.
  - Then, if `rxs == 1`, go to IDLE.
  - If `rxs == 0` (break, or stop sampled low), wait in STOP until `rxs == 1`, then go to IDLE. This prevents false start detection on a held-low line.
- FIFO
  - Width DATA_BITS+2, depth DEPTH.
  - `dout`, `parity_err` and `frame_err` are the head entry.
  - A simultaneous write and `rd_en` while full: the write is treated as dropped, since `full` is evaluated before the read.
  - A simultaneous write and read while non-full leaves `data_count` unchanged.
- Overrun
  - `overrun` set has priority over `clr_overrun` in the same cycle.
  - Otherwise `clr_overrun` clears it next cycle.
- Latency: a frame is visible (`empty` falls) 2 to 3 cycles after the end of the last stop window.
- Window alignment: bit windows are aligned to the cycle the synchronised falling edge is seen, with no mid-bit resynchronisation. Clock mismatch tolerance is bounded by majority voting (about ±4% for 10-bit frames).

Test Plan:
- Default 8N1 with CLK_IN=16, BAUD=1 (N=16): send 0xA5 then 0x3C with ideal timing -> two entries, dout = 0xA5 then 0x3C, both error flags 0, `data_count` goes 0 → 1 → 2.
- 4-cycle low pulse on an idle line -> START rejects it; no FIFO write; `busy` returns to 0 after 16 cycles.
- PARITY=2, DATA_BITS=7: send 0x55 with correct parity bit 0 -> `parity_err = 0`. Send 0x55 with parity bit 1 -> `parity_err = 1`, dout = 0x55.
- STOP_BITS=2: second stop bit held low -> `frame_err = 1`. Hold rx low 40 more cycles -> no new entry until rx rises, then 0x00 with `frame_err` is not repeated.
- DEPTH=4: send 5 frames without reading -> `full = 1` after the 4th, `overrun = 1` after the 5th, entries 1..4 intact. Pulse `clr_overrun` -> `overrun = 0`.
- Noise within bit windows: flip rx for 5 of 16 cycles in each data bit of 0x96 -> dout = 0x96, no errors. Assert `srst_n = 0` mid-frame -> `empty = 1`, nothing written, and the next clean frame is received correctly.
